// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes the pulse-width coded strip waveform into
// 24-bit pixels with frame indexing, end-of-frame and protocol error strobes.
module ws2812_rx #(
   parameter int unsigned NUM_LEDS   = 8,
   parameter int unsigned CLK_MHZ    = 12,
   parameter int unsigned T_BIT      = CLK_MHZ * 600 / 1000,
   parameter int unsigned T_HIGH_MAX = CLK_MHZ * 2000 / 1000,
   parameter int unsigned T_LATCH    = CLK_MHZ * 50
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            din,
   output logic [23:0]                     pixel_rgb,
   output logic [$clog2(NUM_LEDS+1)-1:0]   pixel_index,
   output logic                            pixel_valid,
   output logic                            frame_done,
   output logic [$clog2(NUM_LEDS+1)-1:0]   frame_pixels,
   output logic                            error
);

   localparam int unsigned IW = $clog2(NUM_LEDS + 1);
   localparam int unsigned LW = $clog2(T_LATCH + 1);
   localparam int unsigned HW = $clog2(T_HIGH_MAX + 1);

   typedef enum logic [1:0] {S_SYNC, S_LOW, S_HIGH} state_t;

   state_t          state_q;
   logic            sync1_q, sync2_q;
   logic [LW-1:0]   low_cnt_q;
   logic [HW-1:0]   high_cnt_q;
   logic [4:0]      bit_cnt_q;
   logic            any_bit_q;
   logic [IW-1:0]   pix_cnt_q;
   logic            ovf_q;
   logic [23:0]     shift_q;
   logic [23:0]     shift_d;
   logic            bit_c;

   logic [23:0]     rgb_q;
   logic [IW-1:0]   idx_q;
   logic            valid_q, done_q, err_q;
   logic [IW-1:0]   fpix_q;

   logic            din_s;
   assign din_s   = sync2_q;
   assign bit_c   = (high_cnt_q >= HW'(T_BIT));
   assign shift_d = {shift_q[22:0], bit_c};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_SYNC;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         low_cnt_q  <= '0;
         high_cnt_q <= '0;
         bit_cnt_q  <= '0;
         any_bit_q  <= 1'b0;
         pix_cnt_q  <= '0;
         ovf_q      <= 1'b0;
         shift_q    <= '0;
         rgb_q      <= '0;
         idx_q      <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         fpix_q     <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            // Wait for a full latch-length low before trusting any bit boundary
            S_SYNC: begin
               if (din_s) begin
                  low_cnt_q <= '0;
               end else if (low_cnt_q == LW'(T_LATCH - 1)) begin
                  low_cnt_q <= LW'(T_LATCH);
                  state_q   <= S_LOW;
                  bit_cnt_q <= '0;
                  any_bit_q <= 1'b0;
                  pix_cnt_q <= '0;
                  ovf_q     <= 1'b0;
                  shift_q   <= '0;
               end else begin
                  low_cnt_q <= low_cnt_q + 1'b1;
               end
            end
            S_LOW: begin
               if (din_s) begin
                  state_q    <= S_HIGH;
                  high_cnt_q <= HW'(1);
               end else if (low_cnt_q != LW'(T_LATCH)) begin
                  low_cnt_q <= low_cnt_q + 1'b1;
                  if (low_cnt_q == LW'(T_LATCH - 1) && any_bit_q) begin
                     done_q    <= 1'b1;
                     fpix_q    <= pix_cnt_q;
                     err_q     <= (bit_cnt_q != 5'd0);
                     bit_cnt_q <= '0;
                     any_bit_q <= 1'b0;
                     pix_cnt_q <= '0;
                     ovf_q     <= 1'b0;
                  end
               end
            end
            S_HIGH: begin
               if (!din_s) begin
                  state_q   <= S_LOW;
                  low_cnt_q <= LW'(1);
                  shift_q   <= shift_d;
                  any_bit_q <= 1'b1;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_q <= '0;
                     // Pixels past the strip length are dropped; flag only the first
                     if (pix_cnt_q != IW'(NUM_LEDS)) begin
                        valid_q   <= 1'b1;
                        rgb_q     <= shift_d;
                        idx_q     <= pix_cnt_q;
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                     end else if (!ovf_q) begin
                        err_q <= 1'b1;
                        ovf_q <= 1'b1;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end else if (high_cnt_q == HW'(T_HIGH_MAX - 1)) begin
                  high_cnt_q <= HW'(T_HIGH_MAX);
                  err_q      <= 1'b1;
                  state_q    <= S_SYNC;
                  low_cnt_q  <= '0;
               end else begin
                  high_cnt_q <= high_cnt_q + 1'b1;
               end
            end
            default: state_q <= S_SYNC;
         endcase
      end
   end

   assign pixel_rgb    = rgb_q;
   assign pixel_index  = idx_q;
   assign pixel_valid  = valid_q;
   assign frame_done   = done_q;
   assign frame_pixels = fpix_q;
   assign error        = err_q;

endmodule
